rob_commit: RTL and testbench

Reorder buffer sitting directly downstream of the reservation station. It allocates a 5-bit destination tag for each instruction as it issues, and accepts up to two results per cycle from the two ALU lanes fed by the reservation station. It retires up to two completed instructions per cycle, in program order, to the register file. It also answers operand-tag lookups, so the issue stage can decide whether a source value is already available.

---
 rtl/rob_commit.sv | 180 ++++++++++++++++++
 tb/tb_rob_commit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// Reorder buffer: hands out tags in issue order, accepts two ALU results per cycle,
// answers operand lookups and retires up to two completed entries per cycle in order.
module rob_commit #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  logic [4:0]       alloc_rd,
    output logic [4:0]       alloc_tag,
    output logic             full,
    output logic             empty,
    output logic [IDX_W:0]   count,
    input  logic             wb_valid,
    input  logic [4:0]       wb_tag,
    input  logic [31:0]      wb_value,
    input  logic             wb_valid2,
    input  logic [4:0]       wb_tag2,
    input  logic [31:0]      wb_value2,
    input  logic [4:0]       q1_tag,
    input  logic [4:0]       q2_tag,
    output logic             q1_done,
    output logic [31:0]      q1_value,
    output logic             q2_done,
    output logic [31:0]      q2_value,
    output logic             commit_en,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_value,
    output logic             commit_en2,
    output logic [4:0]       commit_rd2,
    output logic [31:0]      commit_value2
);
    localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [4:0]       rd_q    [DEPTH];
    logic [4:0]       rd_d    [DEPTH];
    logic [31:0]      value_q [DEPTH];
    logic [31:0]      value_d [DEPTH];
    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
    logic [IDX_W:0]   count_q, count_d;

    logic             commit_en_q, commit_en_d, commit_en2_q, commit_en2_d;
    logic [4:0]       commit_rd_q, commit_rd_d, commit_rd2_q, commit_rd2_d;
    logic [31:0]      commit_value_q, commit_value_d, commit_value2_q, commit_value2_d;

    logic             alloc_ok, wb1_hit, wb2_hit, fire1, fire2;
    logic [IDX_W-1:0] wb1_idx, wb2_idx, q1_idx, q2_idx;

    // Same-cycle results take precedence over storage; lane 2 over lane 1.
    function automatic logic [32:0] lookup(
        input logic [4:0]  tag,
        input logic        ent_valid,
        input logic        ent_done,
        input logic [31:0] ent_value,
        input logic        f1_valid,
        input logic [4:0]  f1_tag,
        input logic [31:0] f1_value,
        input logic        f2_valid,
        input logic [4:0]  f2_tag,
        input logic [31:0] f2_value
    );
        logic [32:0] r;
        r = '0;
        if (tag[4] && ent_valid) begin
            if (f2_valid && f2_tag == tag)      r = {1'b1, f2_value};
            else if (f1_valid && f1_tag == tag) r = {1'b1, f1_value};
            else if (ent_done)                  r = {1'b1, ent_value};
        end
        return r;
    endfunction

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign alloc_tag = {1'b1, 4'(tail_q)};
    assign alloc_ok  = alloc && !full;
    assign head_nxt  = head_q + IDX_W'(1);

    assign wb1_idx = wb_tag[IDX_W-1:0];
    assign wb2_idx = wb_tag2[IDX_W-1:0];
    assign q1_idx  = q1_tag[IDX_W-1:0];
    assign q2_idx  = q2_tag[IDX_W-1:0];
    assign wb1_hit = wb_valid  && wb_tag[4]  && valid_q[wb1_idx];
    assign wb2_hit = wb_valid2 && wb_tag2[4] && valid_q[wb2_idx];

    assign fire1 = valid_q[head_q] && done_q[head_q];
    assign fire2 = fire1 && valid_q[head_nxt] && done_q[head_nxt];

    assign {q1_done, q1_value} = lookup(q1_tag, valid_q[q1_idx], done_q[q1_idx], value_q[q1_idx],
                                        wb_valid, wb_tag, wb_value, wb_valid2, wb_tag2, wb_value2);
    assign {q2_done, q2_value} = lookup(q2_tag, valid_q[q2_idx], done_q[q2_idx], value_q[q2_idx],
                                        wb_valid, wb_tag, wb_value, wb_valid2, wb_tag2, wb_value2);

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        rd_d    = rd_q;
        value_d = value_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + (IDX_W + 1)'(alloc_ok) - (IDX_W + 1)'(fire1) - (IDX_W + 1)'(fire2);

        if (wb1_hit) begin
            value_d[wb1_idx] = wb_value;
            done_d[wb1_idx]  = 1'b1;
        end
        if (wb2_hit) begin
            value_d[wb2_idx] = wb_value2;
            done_d[wb2_idx]  = 1'b1;
        end

        // Retire after writeback so a retired slot always ends fully cleared.
        if (fire1) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_nxt;
        end
        if (fire2) begin
            valid_d[head_nxt] = 1'b0;
            done_d[head_nxt]  = 1'b0;
            head_d            = head_nxt + IDX_W'(1);
        end

        if (alloc_ok) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            rd_d[tail_q]    = alloc_rd;
            tail_d          = tail_q + IDX_W'(1);
        end

        commit_en_d     = fire1;
        commit_rd_d     = fire1 ? rd_q[head_q]      : '0;
        commit_value_d  = fire1 ? value_q[head_q]   : '0;
        commit_en2_d    = fire2;
        commit_rd2_d    = fire2 ? rd_q[head_nxt]    : '0;
        commit_value2_d = fire2 ? value_q[head_nxt] : '0;
    end

    // ---- state / commit register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= '0;
            done_q          <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            commit_en_q     <= 1'b0;
            commit_rd_q     <= '0;
            commit_value_q  <= '0;
            commit_en2_q    <= 1'b0;
            commit_rd2_q    <= '0;
            commit_value2_q <= '0;
        end else begin
            valid_q         <= valid_d;
            done_q          <= done_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            commit_en_q     <= commit_en_d;
            commit_rd_q     <= commit_rd_d;
            commit_value_q  <= commit_value_d;
            commit_en2_q    <= commit_en2_d;
            commit_rd2_q    <= commit_rd2_d;
            commit_value2_q <= commit_value2_d;
        end
        rd_q    <= rd_d;
        value_q <= value_d;
    end

    assign commit_en     = commit_en_q;
    assign commit_rd     = commit_rd_q;
    assign commit_value  = commit_value_q;
    assign commit_en2    = commit_en2_q;
    assign commit_rd2    = commit_rd2_q;
    assign commit_value2 = commit_value2_q;

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: expected retirements are queued at allocation
// and matched against the commit ports by a negedge monitor.
module tb_rob_commit;
    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst, alloc;
    logic [4:0]       alloc_rd, alloc_tag;
    logic             full, empty;
    logic [IDX_W:0]   count;
    logic             wb_valid, wb_valid2;
    logic [4:0]       wb_tag, wb_tag2, q1_tag, q2_tag;
    logic [31:0]      wb_value, wb_value2, q1_value, q2_value;
    logic             q1_done, q2_done;
    logic             commit_en, commit_en2;
    logic [4:0]       commit_rd, commit_rd2;
    logic [31:0]      commit_value, commit_value2;

    rob_commit #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .alloc(alloc), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
        .full(full), .empty(empty), .count(count),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .wb_valid2(wb_valid2), .wb_tag2(wb_tag2), .wb_value2(wb_value2),
        .q1_tag(q1_tag), .q2_tag(q2_tag),
        .q1_done(q1_done), .q1_value(q1_value), .q2_done(q2_done), .q2_value(q2_value),
        .commit_en(commit_en), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_en2(commit_en2), .commit_rd2(commit_rd2), .commit_value2(commit_value2)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    logic [36:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wb_drive(input logic v1, input logic [4:0] t1, input logic [31:0] d1,
                            input logic v2, input logic [4:0] t2, input logic [31:0] d2);
        wb_valid = v1; wb_tag = t1; wb_value = d1;
        wb_valid2 = v2; wb_tag2 = t2; wb_value2 = d2;
    endtask

    // Retirements must come out in program order, slot 1 before slot 2.
    always @(negedge clk) begin
        logic [36:0] e;
        check("slot2_without_slot1", 64'(commit_en2 & ~commit_en), 64'd0);
        if (commit_en) begin
            if (exp_q.size() == 0) check("commit_unexpected", 64'(commit_en), 64'd0);
            else begin
                e = exp_q.pop_front();
                check("commit_slot1", 64'({commit_rd, commit_value}), 64'(e));
            end
        end
        if (commit_en2) begin
            if (exp_q.size() == 0) check("commit2_unexpected", 64'(commit_en2), 64'd0);
            else begin
                e = exp_q.pop_front();
                check("commit_slot2", 64'({commit_rd2, commit_value2}), 64'(e));
            end
        end
    end

    initial begin
        rst = 1'b1; alloc = 1'b0; alloc_rd = '0; q1_tag = '0; q2_tag = '0;
        wb_drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state and first allocation
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_commit", 64'({commit_en, commit_rd, commit_value, commit_en2}), 64'd0);
        alloc = 1'b1; alloc_rd = 5'd3;
        #1;
        check("first_tag", 64'(alloc_tag), 64'h10);
        exp_q.push_back({5'd3, 32'h33});
        tick();
        alloc = 1'b0;
        check("first_count", 64'(count), 64'd1);
        check("first_no_commit", 64'(commit_en), 64'd0);
        wb_drive(1'b1, 5'h10, 32'h33, 1'b0, 5'd0, 32'd0);
        tick();
        wb_drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("lat_not_yet", 64'(commit_en), 64'd0);
        tick();
        check("lat_commit", 64'({commit_en, commit_rd, commit_value}), 64'({1'b1, 5'd3, 32'h33}));
        tick();
        check("lat_one_cycle", 64'(commit_en), 64'd0);

        // In-order retire with out-of-order completion
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc = 1'b1; alloc_rd = 5'(5 + i);
            #1;
            check("io_tag", 64'(alloc_tag), 64'(5'h10 + 5'(i)));
            exp_q.push_back({5'(5 + i), 32'hA + 32'(i)});
            tick();
        end
        alloc = 1'b0;
        wb_drive(1'b1, 5'h12, 32'hC, 1'b0, 5'd0, 32'd0);
        tick();
        wb_drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
        check("io_blocked", 64'(commit_en), 64'd0);
        wb_drive(1'b1, 5'h10, 32'hA, 1'b1, 5'h11, 32'hB);
        tick();
        wb_drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("io_blocked2", 64'(commit_en), 64'd0);
        tick();
        check("io_dual", 64'({commit_en, commit_rd, commit_value, commit_en2, commit_rd2}),
              64'({1'b1, 5'd5, 32'hA, 1'b1, 5'd6}));
        check("io_dual_val2", 64'(commit_value2), 64'hB);
        tick();
        check("io_third", 64'({commit_en, commit_rd, commit_value, commit_en2}),
              64'({1'b1, 5'd7, 32'hC, 1'b0}));
        tick();
        check("io_idle", 64'({commit_en, commit_rd, commit_value, commit_en2, commit_rd2, commit_value2}), 64'd0);
        check("io_empty", 64'({empty, count}), 64'({1'b1, 5'd0}));

        // Lookup forwarding and lane priority
        do_reset();
        alloc = 1'b1; alloc_rd = 5'd8;
        exp_q.push_back({5'd8, 32'h44});
        tick();
        alloc_rd = 5'd9;
        exp_q.push_back({5'd9, 32'h55});
        tick();
        alloc = 1'b0; q1_tag = 5'h11;
        #1;
        check("lk_pending", 64'({q1_done, q1_value}), 64'd0);
        wb_drive(1'b0, 5'd0, 32'd0, 1'b1, 5'h11, 32'h55);
        #1;
        check("lk_forward", 64'({q1_done, q1_value}), 64'({1'b1, 32'h55}));
        tick();
        wb_drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("lk_stored", 64'({q1_done, q1_value}), 64'({1'b1, 32'h55}));
        check("lk_no_commit", 64'(commit_en), 64'd0);
        q2_tag = 5'h10;
        wb_drive(1'b1, 5'h10, 32'h11, 1'b1, 5'h10, 32'h44);
        #1;
        check("lk_lane2_wins", 64'({q2_done, q2_value}), 64'({1'b1, 32'h44}));
        tick();
        wb_drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("lk_lane2_stored", 64'({q2_done, q2_value}), 64'({1'b1, 32'h44}));
        tick();
        tick();
        check("lk_drained", 64'({empty, count}), 64'({1'b1, 5'd0}));
        check("lk_retired_gone", 64'({q1_done, q1_value}), 64'd0);

        // Results for tag 0 or an unallocated entry are dropped
        q1_tag = 5'h00; q2_tag = 5'h15;
        wb_drive(1'b1, 5'h00, 32'hDEAD, 1'b1, 5'h15, 32'hBEEF);
        #1;
        check("inv_q1_tag0", 64'({q1_done, q1_value}), 64'd0);
        tick();
        wb_drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("inv_q2_stored", 64'({q2_done, q2_value}), 64'd0);
        tick();
        check("inv_state", 64'({empty, count, commit_en}), 64'({1'b1, 5'd0, 1'b0}));

        // Full, ignored allocation, wrap of tail/head/head+1
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            alloc = 1'b1; alloc_rd = 5'(i + 1);
            #1;
            check("full_tag", 64'(alloc_tag), 64'({1'b1, 4'(i)}));
            exp_q.push_back({5'(i + 1), 32'h100 + 32'(i)});
            tick();
        end
        check("full_flag", 64'({full, empty, count, alloc_tag}), 64'({1'b1, 1'b0, 5'd16, 5'h10}));
        tick();
        alloc = 1'b0;
        check("full_ignored", 64'(count), 64'd16);
        wb_drive(1'b1, 5'h10, 32'h100, 1'b0, 5'd0, 32'd0);
        tick();
        wb_drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        alloc = 1'b1; alloc_rd = 5'd20;
        tick();
        check("full_no_same_cycle", 64'({full, count, alloc_tag}), 64'({1'b0, 5'd15, 5'h10}));
        exp_q.push_back({5'd20, 32'h200});
        tick();
        alloc = 1'b0;
        check("full_again", 64'({full, count}), 64'({1'b1, 5'd16}));
        for (int k = 1; k < DEPTH; k += 2) begin
            wb_drive(1'b1, {1'b1, 4'(k)}, 32'h100 + 32'(k),
                     1'b1, {1'b1, 4'(k + 1)}, (k + 1 == DEPTH) ? 32'h200 : 32'h100 + 32'(k + 1));
            tick();
        end
        wb_drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("full_drained", 64'({empty, count}), 64'({1'b1, 5'd0}));

        // Reset with completed entries in flight
        do_reset();
        alloc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            alloc_rd = 5'(10 + i);
            tick();
        end
        alloc = 1'b0;
        wb_drive(1'b1, 5'h11, 32'h1, 1'b1, 5'h12, 32'h2);
        tick();
        wb_drive(1'b1, 5'h13, 32'h3, 1'b1, 5'h14, 32'h4);
        tick();
        wb_drive(1'b1, 5'h15, 32'h5, 1'b0, 5'd0, 32'd0);
        tick();
        wb_drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        check("mr_before", 64'({count, commit_en}), 64'({5'd6, 1'b0}));
        do_reset();
        check("mr_after", 64'({empty, count, commit_en}), 64'({1'b1, 5'd0, 1'b0}));
        wb_drive(1'b1, 5'h10, 32'h77, 1'b0, 5'd0, 32'd0);
        tick();
        wb_drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr_no_commit", 64'({commit_en, commit_en2}), 64'd0);
        end
        check("mr_empty", 64'({empty, count}), 64'({1'b1, 5'd0}));

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
